// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, complex sample type, read FSM states and bit-reversal helper
package fft_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N_POINTS = 16;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] re;
    logic [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;
  typedef enum logic {IDLE, READ} rd_state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r = {r[30:0], v[i]};
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_if.sv
// fft_reorder_if: bit-reversed complex stream in, natural-order stream out
interface fft_reorder_if import fft_pkg::*; #(parameter int DATA_WIDTH = DEF_DATA_WIDTH);
  logic a_val;
  logic [DATA_WIDTH-1:0] a_re;
  logic [DATA_WIDTH-1:0] a_im;
  logic b_val;
  logic b_first;
  logic b_last;
  logic [DATA_WIDTH-1:0] b_re;
  logic [DATA_WIDTH-1:0] b_im;
  modport master (output a_val, a_re, a_im, input b_val, b_first, b_last, b_re, b_im);
  modport slave (input a_val, a_re, a_im, output b_val, b_first, b_last, b_re, b_im);
endinterface

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: simple dual-port RAM, one write port, one registered read port
module fft_reorder_bank import fft_pkg::*; #(
  parameter int WIDTH = 2 * DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_N_POINTS,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong buffer turning the bit-reversed FFT output into natural order
module fft_reorder import fft_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_POINTS = DEF_N_POINTS
) (
  input logic clk,
  input logic rst,
  fft_reorder_if.slave io
);
  localparam int LOG2N = $clog2(N_POINTS);
  localparam int W = 2 * DATA_WIDTH;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);
  rd_state_t r_state;
  logic [LOG2N-1:0] r_wr_cnt, r_rd_cnt;
  logic r_wr_bank, r_rd_bank, r_q_bank;
  logic [1:0] r_full;
  logic w_wrap, w_end, w_other_full;
  logic [1:0] w_set, w_clr;
  logic [LOG2N-1:0] w_waddr;
  logic [W-1:0] w_q [2];
  assign w_wrap = io.a_val && r_wr_cnt == LAST;
  assign w_end = r_state == READ && r_rd_cnt == LAST;
  assign w_set = w_wrap ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_end ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
  // the other bank may complete on the very edge this one drains
  assign w_other_full = r_full[!r_rd_bank] | w_set[!r_rd_bank];
  assign w_waddr = LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.WIDTH(W), .DEPTH(N_POINTS)) u_bank (
      .clk(clk),
      .rst(rst),
      .i_we(io.a_val && r_wr_bank == 1'(b)),
      .i_waddr(w_waddr),
      .i_wdata({io.a_re, io.a_im}),
      .i_re(r_state == READ && r_rd_bank == 1'(b)),
      .i_raddr(r_rd_cnt),
      .o_rdata(w_q[b])
    );
  end
  assign {io.b_re, io.b_im} = w_q[r_q_bank];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_q_bank <= 1'b0;
      r_full <= 2'b00;
      io.b_val <= 1'b0;
      io.b_first <= 1'b0;
      io.b_last <= 1'b0;
    end else begin
      if (io.a_val) r_wr_cnt <= r_wr_cnt + LOG2N'(1);
      if (w_wrap) r_wr_bank <= ~r_wr_bank;
      r_full <= (r_full | w_set) & ~w_clr;
      io.b_val <= r_state == READ;
      io.b_first <= r_state == READ && r_rd_cnt == '0;
      io.b_last <= w_end;
      r_q_bank <= r_state == READ ? r_rd_bank : r_q_bank;
      if (r_state == IDLE) begin
        if (|r_full) begin
          r_state <= READ;
          r_rd_bank <= ~r_full[0];
          r_rd_cnt <= '0;
        end
      end else begin
        r_rd_cnt <= r_rd_cnt + LOG2N'(1);
        if (w_end && !w_other_full) r_state <= IDLE;
        else if (w_end) r_rd_bank <= ~r_rd_bank;
      end
    end
  end
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: randomized frames checked against a natural-order frame model
module tb_fft_reorder;
  import fft_pkg::*;
  localparam int N = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int vcnt = 0, fcnt = 0, lcnt = 0, run = 0, max_run = 0;
  logic [33:0] exp_q [$];
  cplx_t in_buf [N];
  int in_cnt = 0;
  fft_reorder_if #(.DATA_WIDTH(16)) bus ();
  fft_reorder #(.DATA_WIDTH(16), .N_POINTS(N)) dut (.clk(clk), .rst(rst), .io(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < 4; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction
  task automatic send(input logic [15:0] re, input logic [15:0] im);
    @(posedge clk);
    #1;
    bus.a_val = 1'b1;
    bus.a_re = re;
    bus.a_im = im;
    in_buf[in_cnt] = '{re: re, im: im};
    in_cnt++;
    if (in_cnt == N) begin
      for (int n = 0; n < N; n++)
        exp_q.push_back({in_buf[brev(n)].re, in_buf[brev(n)].im, n == 0, n == N - 1});
      in_cnt = 0;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.a_val = 1'b0;
    end
  endtask
  task automatic send_frame(input int mode, input int base, input int gap);
    logic [15:0] re, im;
    for (int k = 0; k < N; k++) begin
      re = 16'(base + brev(k));
      im = ~16'(brev(k));
      if (mode == 1) begin
        re = k[0] ? 16'h8000 : 16'h7FFF;
        im = k[0] ? 16'h7FFF : 16'h8000;
      end else if (mode == 2) begin
        re = 16'($urandom);
        im = 16'($urandom);
      end
      send(re, im);
      if (gap == 1) idle(1);
      else if (gap == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
  endtask
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.a_val = 1'b0;
    exp_q.delete();
    in_cnt = 0;
    #1;
    chk({tag, "_rst"}, 64'({bus.b_val, bus.b_first, bus.b_last, bus.b_re, bus.b_im}), 64'd0);
    idle(2);
    rst = 1'b0;
  endtask
  task automatic latency(input string tag);
    @(negedge clk);
    chk({tag, "_e0"}, 64'(bus.b_val), 64'd0);
    @(negedge clk);
    chk({tag, "_e1"}, 64'(bus.b_val), 64'd0);
    @(negedge clk);
    chk({tag, "_e2"}, 64'({bus.b_val, bus.b_first, bus.b_re}), {46'd0, 2'b11, 16'd0});
  endtask
  always @(negedge clk) begin
    if (!rst && bus.b_val) begin
      vcnt++;
      fcnt += int'(bus.b_first);
      lcnt += int'(bus.b_last);
      run++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) chk("unexpected_val", 64'd1, 64'd0);
      else chk("out", 64'({bus.b_re, bus.b_im, bus.b_first, bus.b_last}), 64'(exp_q.pop_front()));
    end else run = 0;
  end
  initial begin
    int v0, f0, l0;
    bool_wait: begin end
    bus.a_val = 1'b0;
    bus.a_re = '0;
    bus.a_im = '0;
    #2;
    do_reset("init");
    idle(2);
    send_frame(0, 0, 0);
    idle(1);
    latency("t1");
    idle(20);
    send_frame(0, 0, 1);
    latency("t2");
    idle(20);
    v0 = vcnt; f0 = fcnt; l0 = lcnt; max_run = 0;
    for (int f = 0; f < 3; f++) send_frame(0, 16 * f, 0);
    idle(25);
    chk("t3_vals", 64'(vcnt - v0), 64'd48);
    chk("t3_firsts", 64'(fcnt - f0), 64'd3);
    chk("t3_lasts", 64'(lcnt - l0), 64'd3);
    chk("t3_run", 64'(max_run), 64'd48);
    for (int k = 0; k < 9; k++) send(16'h1000 + 16'(k), 16'h2000);
    do_reset("t4");
    v0 = vcnt;
    idle(25);
    chk("t4_quiet", 64'(vcnt), 64'(v0));
    send_frame(0, 100, 0);
    idle(25);
    chk("t4_clean", 64'(vcnt - v0), 64'd16);
    send_frame(0, 0, 0);
    idle(1);
    begin
      int t;
      for (t = 0; t < 40 && !(bus.b_val && bus.b_re == 16'd5); t++) @(negedge clk);
      chk("t5_seen_x5", 64'(t < 40), 64'd1);
    end
    #1;
    do_reset("t5");
    v0 = vcnt;
    idle(30);
    chk("t5_quiet", 64'(vcnt), 64'(v0));
    send_frame(1, 0, 0);
    idle(25);
    for (int f = 0; f < 6; f++) send_frame(2, 0, (f % 2 == 0) ? 2 : 0);
    idle(40);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
